muldiv_sequencer: RTL and testbench

- Iterative RV32M multiply/divide unit behind ExecuteUnitType_MulDiv.
- Accepts one MulDivCommand with two operands, then sequences a radix-2 shift-add multiplier or restoring divider for WIDTH iterations.
- Handles sign fix-up and the divide special cases, and presents a one-cycle done pulse with the result.
- Sits in the execute stage; the pipeline stalls on busy and flushes it on trap or branch mispredict.

---
 rtl/muldiv_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiplier and
// restoring divider, one iteration per cycle, with sign fix-up and the
// divide-by-zero / signed-overflow special cases resolved at start.
module muldiv_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [2:0]       command,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned CntWidth  = $clog2(WIDTH);
    localparam int unsigned ProdWidth = 2 * WIDTH;
    localparam int unsigned AccWidth  = 2 * WIDTH + 1;

    localparam logic [CntWidth-1:0] LastIter = CntWidth'(WIDTH - 1);
    localparam logic [WIDTH-1:0]    MostNeg  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0]    AllOnes  = '1;

    localparam logic [2:0] CmdMul    = 3'd0;
    localparam logic [2:0] CmdMulh   = 3'd1;
    localparam logic [2:0] CmdMulhsu = 3'd2;
    localparam logic [2:0] CmdMulhu  = 3'd3;
    localparam logic [2:0] CmdDiv    = 3'd4;
    localparam logic [2:0] CmdDivu   = 3'd5;
    localparam logic [2:0] CmdRem    = 3'd6;
    localparam logic [2:0] CmdRemu   = 3'd7;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } stateT;

    stateT state;
    stateT stateNext;

    logic [CntWidth-1:0] counter;
    logic [2:0]          cmdReg;
    logic                negResult;
    logic [AccWidth-1:0] acc;        // mul: {carry, high, multiplier}; div: {0, remainder, quotient}
    logic [WIDTH-1:0]    opB;        // multiplicand or divisor magnitude

    // Start-time decode of the incoming command and operands
    logic             isDivCmd;
    logic             isRemCmd;
    logic             sign1;
    logic             sign2;
    logic [WIDTH-1:0] mag1;
    logic [WIDTH-1:0] mag2;
    logic             negStart;
    logic             special;
    logic [WIDTH-1:0] specialResult;
    logic [AccWidth-1:0] accStart;
    logic [WIDTH-1:0] opBStart;

    // Per-iteration datapath and final result formatting
    logic [WIDTH:0]      mulSum;
    logic [AccWidth-1:0] mulNext;
    logic [WIDTH:0]      divShift;
    logic [WIDTH:0]      divTrial;
    logic [AccWidth-1:0] divNext;
    logic [AccWidth-1:0] accIter;
    logic [ProdWidth-1:0] product;
    logic [ProdWidth-1:0] productSigned;
    logic [WIDTH-1:0]    quotient;
    logic [WIDTH-1:0]    remainder;
    logic [WIDTH-1:0]    finalResult;

    // FSM controls
    logic startOp;
    logic iterStep;
    logic finishOp;

    // Decode operands: signedness, magnitudes, negate flag and special cases
    always_comb begin
        isDivCmd      = command[2];
        isRemCmd      = command[2] & command[1];
        sign1         = 1'b0;
        sign2         = 1'b0;
        special       = 1'b0;
        specialResult = '0;

        if ((command == CmdMulh) || (command == CmdMulhsu) ||
            (command == CmdDiv)  || (command == CmdRem)) begin
            sign1 = src1[WIDTH-1];
        end
        if ((command == CmdMulh) || (command == CmdDiv) || (command == CmdRem)) begin
            sign2 = src2[WIDTH-1];
        end

        mag1     = sign1 ? (~src1 + WIDTH'(1)) : src1;
        mag2     = sign2 ? (~src2 + WIDTH'(1)) : src2;
        negStart = isRemCmd ? sign1 : (sign1 ^ sign2);

        if (isDivCmd && (src2 == '0)) begin
            special       = 1'b1;
            specialResult = isRemCmd ? src1 : AllOnes;
        end else if (((command == CmdDiv) || (command == CmdRem)) &&
                     (src1 == MostNeg) && (src2 == AllOnes)) begin
            special       = 1'b1;
            specialResult = isRemCmd ? '0 : MostNeg;
        end

        accStart = {{(WIDTH+1){1'b0}}, (isDivCmd ? mag1 : mag2)};
        opBStart = isDivCmd ? mag2 : mag1;
    end

    // One shift-add or restoring-divide step, plus sign fix-up of the outcome
    always_comb begin
        mulSum  = acc[2*WIDTH:WIDTH] + {1'b0, opB};
        mulNext = acc[0] ? {1'b0, mulSum, acc[WIDTH-1:1]}
                         : {1'b0, acc[2*WIDTH:WIDTH], acc[WIDTH-1:1]};

        divShift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        divTrial = divShift - {1'b0, opB};
        divNext  = divTrial[WIDTH] ? {1'b0, divShift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                   : {1'b0, divTrial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

        accIter = cmdReg[2] ? divNext : mulNext;

        product       = accIter[ProdWidth-1:0];
        productSigned = negResult ? (~product + ProdWidth'(1)) : product;
        quotient      = accIter[WIDTH-1:0];
        remainder     = accIter[2*WIDTH-1:WIDTH];

        case (cmdReg)
            CmdMul:                       finalResult = productSigned[WIDTH-1:0];
            CmdMulh, CmdMulhsu, CmdMulhu: finalResult = productSigned[ProdWidth-1:WIDTH];
            CmdDiv, CmdDivu:              finalResult = negResult ? (~quotient + WIDTH'(1)) : quotient;
            CmdRem, CmdRemu:              finalResult = negResult ? (~remainder + WIDTH'(1)) : remainder;
            default:                      finalResult = '0;
        endcase
    end

    // Next-state and datapath control; flush aborts everything
    always_comb begin
        stateNext = state;
        startOp   = 1'b0;
        iterStep  = 1'b0;
        finishOp  = 1'b0;

        case (state)
            StIdle: begin
                if (enable && !flush) begin
                    startOp   = 1'b1;
                    stateNext = special ? StDone : StRun;
                end
            end
            StRun: begin
                if (flush) begin
                    stateNext = StIdle;
                end else begin
                    iterStep = 1'b1;
                    if (counter == LastIter) begin
                        finishOp  = 1'b1;
                        stateNext = StDone;
                    end
                end
            end
            StDone: begin
                stateNext = StIdle;
            end
            default: begin
                stateNext = StIdle;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= StIdle;
        end else begin
            state <= stateNext;
        end
    end

    // Operand latch, iteration registers and result register
    always_ff @(posedge clk) begin
        if (rst) begin
            counter   <= '0;
            cmdReg    <= CmdMul;
            negResult <= 1'b0;
            acc       <= '0;
            opB       <= '0;
            result    <= '0;
        end else begin
            if (startOp) begin
                counter   <= '0;
                cmdReg    <= command;
                negResult <= negStart;
                acc       <= accStart;
                opB       <= opBStart;
                if (special) begin
                    result <= specialResult;
                end
            end
            if (iterStep) begin
                acc     <= accIter;
                counter <= counter + CntWidth'(1);
            end
            if (finishOp) begin
                result <= finalResult;
            end
        end
    end

    assign busy = (state != StIdle);
    assign done = (state == StDone) && !flush && !rst;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed RV32M vectors, timing,
// flush/reset/enable-while-busy boundaries and randomized ops vs. a model.
module tb_muldiv_sequencer;

    localparam int unsigned WIDTH = 32;

    logic             clk;
    logic             rst;
    logic             enable;
    logic [2:0]       command;
    logic [WIDTH-1:0] src1;
    logic [WIDTH-1:0] src2;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    int passCount;
    int checkCount;

    typedef struct {
        logic [2:0]  cmd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vecT;

    muldiv_sequencer #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .command (command),
        .src1    (src1),
        .src2    (src2),
        .flush   (flush),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; outputs are read 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference RV32M semantics using plain 64-bit arithmetic
    function automatic logic [31:0] refModel(input logic [2:0] cmd, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'd0, b});
        case (cmd)
            3'd0: begin p = 64'(sa * sb); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                return 32'(sa / sb);
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFFFFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
                return 32'(sa % sb);
            end
            default: begin
                if (b == 32'd0) return a;
                return a % b;
            end
        endcase
    endfunction

    // Latency rule: divide by zero and signed overflow finish immediately
    function automatic int refLatency(input logic [2:0] cmd, input logic [31:0] a, input logic [31:0] b);
        if (cmd >= 3'd4 && b == 32'd0) return 1;
        if ((cmd == 3'd4 || cmd == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
        return 33;
    endfunction

    // Operand generator biased toward the interesting corners
    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'h80000000;
            2:       return 32'hFFFFFFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    // Issue one op in the current cycle; report result, done cycle and pulse count.
    // Returns in the cycle after done (or after the bound expires, lat = -1).
    task automatic runOp(input logic [2:0] cmd, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output int pulses);
        res    = 32'hxxxxxxxx;
        lat    = -1;
        pulses = 0;
        enable  = 1'b1;
        command = cmd;
        src1    = a;
        src2    = b;
        step();
        enable  = 1'b0;
        command = 3'($urandom);
        src1    = 32'($urandom);
        src2    = 32'($urandom);
        for (int c = 1; c <= 40; c++) begin
            if (done === 1'b1) begin
                pulses++;
                if (lat < 0) begin
                    lat = c;
                    res = result;
                end
            end
            if (lat >= 0 && c == lat + 1) break;
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; command = 3'd0; src1 = 32'd5; src2 = 32'd6; flush = 1'b0;
        step();
        step();
        checkCount++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passCount++;
        checkCount++;
        if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else passCount++;
        checkCount++;
        if (result !== 32'd0) $display("FAIL reset_result: got %h expected 00000000", result); else passCount++;
        rst = 1'b0; enable = 1'b0;
        step();
        checkCount++;
        if (busy !== 1'b0) $display("FAIL reset_idle_busy: got %b expected 0", busy); else passCount++;
    endtask

    task automatic test_mul_timing();
        logic expBusy;
        logic expDone;
        enable = 1'b1; command = 3'd0; src1 = 32'd7; src2 = 32'hFFFFFFFD;
        step();
        enable = 1'b0; src1 = 32'($urandom); src2 = 32'($urandom);
        for (int c = 1; c <= 34; c++) begin
            expBusy = (c <= 33);
            expDone = (c == 33);
            checkCount++;
            if (busy !== expBusy) $display("FAIL timing_busy cycle %0d: got %b expected %b", c, busy, expBusy); else passCount++;
            checkCount++;
            if (done !== expDone) $display("FAIL timing_done cycle %0d: got %b expected %b", c, done, expDone); else passCount++;
            if (c == 33) begin
                checkCount++;
                if (result !== 32'hFFFFFFEB) $display("FAIL timing_result: got %h expected ffffffeb", result); else passCount++;
            end
            if (c < 34) step();
        end
    endtask

    task automatic test_directed();
        vecT         vecs [12];
        logic [31:0] res;
        int          lat;
        int          pulses;
        vecs = '{
            '{3'd0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 33},
            '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33},
            '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33},
            '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33},
            '{3'd4, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33},
            '{3'd6, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33},
            '{3'd5, 32'd100,      32'd7,        32'd14,       33},
            '{3'd7, 32'd100,      32'd7,        32'd2,        33},
            '{3'd5, 32'h12345678, 32'h00000000, 32'hFFFFFFFF, 1},
            '{3'd6, 32'd5,        32'd0,        32'd5,        1},
            '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1},
            '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1}
        };
        for (int i = 0; i < 12; i++) begin
            runOp(vecs[i].cmd, vecs[i].a, vecs[i].b, res, lat, pulses);
            checkCount++;
            if (res !== vecs[i].exp) $display("FAIL directed_result[%0d]: got %h expected %h", i, res, vecs[i].exp); else passCount++;
            checkCount++;
            if (lat !== vecs[i].lat) $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, vecs[i].lat); else passCount++;
            checkCount++;
            if (pulses !== 1) $display("FAIL directed_pulses[%0d]: got %0d expected 1", i, pulses); else passCount++;
        end
    endtask

    task automatic test_flush();
        logic [31:0] res;
        int          lat;
        int          pulses;
        logic        sawDone;
        // Flush mid-Run at cycle 10
        sawDone = 1'b0;
        enable = 1'b1; command = 3'd4; src1 = 32'($urandom); src2 = 32'd3;
        step();
        enable = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            if (done === 1'b1) sawDone = 1'b1;
            step();
        end
        flush = 1'b1;
        if (done === 1'b1) sawDone = 1'b1;
        step();
        flush = 1'b0;
        checkCount++;
        if (busy !== 1'b0) $display("FAIL flush_run_busy: got %b expected 0", busy); else passCount++;
        checkCount++;
        if ((sawDone | done) !== 1'b0) $display("FAIL flush_run_done: got %b expected 0", sawDone | done); else passCount++;
        // Restart in cycle 11: done lands at cycle 44
        runOp(3'd0, 32'd3, 32'd4, res, lat, pulses);
        checkCount++;
        if (lat + 11 !== 44) $display("FAIL flush_restart_cycle: got %0d expected 44", lat + 11); else passCount++;
        checkCount++;
        if (res !== 32'd12) $display("FAIL flush_restart_result: got %h expected 0000000c", res); else passCount++;
        // Flush on the final iteration edge: no done
        enable = 1'b1; command = 3'd0; src1 = 32'd9; src2 = 32'd9;
        step();
        enable = 1'b0;
        for (int c = 1; c <= 31; c++) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        checkCount++;
        if (done !== 1'b0) $display("FAIL flush_wrap_done: got %b expected 0", done); else passCount++;
        checkCount++;
        if (busy !== 1'b0) $display("FAIL flush_wrap_busy: got %b expected 0", busy); else passCount++;
        // Flush during the Done cycle suppresses the pulse
        enable = 1'b1; command = 3'd5; src1 = 32'd100; src2 = 32'd7;
        step();
        enable = 1'b0;
        for (int c = 1; c <= 32; c++) step();
        checkCount++;
        if (done !== 1'b1) $display("FAIL flush_done_pre: got %b expected 1", done); else passCount++;
        flush = 1'b1;
        #1;
        checkCount++;
        if (done !== 1'b0) $display("FAIL flush_done_forced: got %b expected 0", done); else passCount++;
        step();
        flush = 1'b0;
        checkCount++;
        if (busy !== 1'b0) $display("FAIL flush_done_busy: got %b expected 0", busy); else passCount++;
        // Flush with enable in Idle suppresses the start
        enable = 1'b1; flush = 1'b1; command = 3'd0; src1 = 32'd2; src2 = 32'd2;
        step();
        enable = 1'b0; flush = 1'b0;
        checkCount++;
        if (busy !== 1'b0) $display("FAIL flush_idle_start: got %b expected 0", busy); else passCount++;
        step();
    endtask

    task automatic test_enable_while_busy();
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expRes;
        a = 32'($urandom);
        b = 32'($urandom);
        expRes = refModel(3'd2, a, b);
        enable = 1'b1; command = 3'd2; src1 = a; src2 = b;
        step();
        for (int c = 1; c <= 32; c++) begin
            enable  = (c >= 5 && c <= 12);
            command = 3'($urandom);
            src1    = 32'($urandom);
            src2    = 32'($urandom);
            step();
        end
        checkCount++;
        if (done !== 1'b1) $display("FAIL busy_enable_done: got %b expected 1", done); else passCount++;
        checkCount++;
        if (result !== expRes) $display("FAIL busy_enable_result: got %h expected %h", result, expRes); else passCount++;
        // Enable during Done is ignored
        enable = 1'b1; command = 3'd0; src1 = 32'd1; src2 = 32'd1;
        step();
        enable = 1'b0;
        checkCount++;
        if (busy !== 1'b0) $display("FAIL done_enable_busy: got %b expected 0", busy); else passCount++;
        checkCount++;
        if (done !== 1'b0) $display("FAIL done_enable_done: got %b expected 0", done); else passCount++;
    endtask

    task automatic test_rst_mid();
        logic [31:0] res;
        int          lat;
        int          pulses;
        logic [31:0] a;
        logic [31:0] b;
        runOp(3'd0, 32'd5, 32'd7, res, lat, pulses);
        checkCount++;
        if (result !== 32'd35) $display("FAIL result_hold: got %h expected 00000023", result); else passCount++;
        enable = 1'b1; command = 3'd0; src1 = 32'($urandom) | 32'd1; src2 = 32'($urandom) | 32'd1;
        step();
        enable = 1'b0;
        for (int c = 1; c <= 19; c++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkCount++;
        if (busy !== 1'b0) $display("FAIL rst_mid_busy: got %b expected 0", busy); else passCount++;
        checkCount++;
        if (done !== 1'b0) $display("FAIL rst_mid_done: got %b expected 0", done); else passCount++;
        checkCount++;
        if (result !== 32'd0) $display("FAIL rst_mid_result: got %h expected 00000000", result); else passCount++;
        a = 32'($urandom);
        b = 32'($urandom);
        runOp(3'd3, a, b, res, lat, pulses);
        checkCount++;
        if (res !== refModel(3'd3, a, b)) $display("FAIL rst_recover_result: got %h expected %h", res, refModel(3'd3, a, b)); else passCount++;
    endtask

    task automatic test_random();
        logic [2:0]  cmd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
        int          pulses;
        for (int i = 0; i < 40; i++) begin
            cmd = 3'($urandom_range(0, 7));
            a   = pickOperand();
            b   = pickOperand();
            runOp(cmd, a, b, res, lat, pulses);
            checkCount++;
            if (res !== refModel(cmd, a, b))
                $display("FAIL random_result[%0d] cmd=%0d a=%h b=%h: got %h expected %h", i, cmd, a, b, res, refModel(cmd, a, b));
            else passCount++;
            checkCount++;
            if (lat !== refLatency(cmd, a, b))
                $display("FAIL random_latency[%0d] cmd=%0d: got %0d expected %0d", i, cmd, lat, refLatency(cmd, a, b));
            else passCount++;
            checkCount++;
            if (pulses !== 1) $display("FAIL random_pulses[%0d]: got %0d expected 1", i, pulses); else passCount++;
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  cmds [6];
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
        int          pulses;
        cmds = '{3'd5, 3'd1, 3'd7, 3'd0, 3'd6, 3'd2};
        for (int i = 0; i < 6; i++) begin
            a = 32'($urandom);
            b = (i == 0 || i == 4) ? 32'd0 : 32'($urandom);
            checkCount++;
            if (busy !== 1'b0) $display("FAIL b2b_idle_busy[%0d]: got %b expected 0", i, busy); else passCount++;
            runOp(cmds[i], a, b, res, lat, pulses);
            checkCount++;
            if (res !== refModel(cmds[i], a, b)) $display("FAIL b2b_result[%0d]: got %h expected %h", i, res, refModel(cmds[i], a, b)); else passCount++;
            checkCount++;
            if (lat !== refLatency(cmds[i], a, b)) $display("FAIL b2b_latency[%0d]: got %0d expected %0d", i, lat, refLatency(cmds[i], a, b)); else passCount++;
        end
    endtask

    initial begin
        passCount  = 0;
        checkCount = 0;
        rst     = 1'b1;
        enable  = 1'b0;
        command = 3'd0;
        src1    = 32'd0;
        src2    = 32'd0;
        flush   = 1'b0;
        test_reset();
        test_mul_timing();
        test_directed();
        test_flush();
        test_enable_while_busy();
        test_rst_mid();
        test_random();
        test_back_to_back();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
